// File: rtl/key_filter_if.sv
// ---------------------------------------------------------------------------
// key_filter_if
// Purpose : groups the key debouncer's data signals into one bundle so the
//           filter and whatever drives/observes it share a single port.
// Signals : key_in      raw mechanical key level, asynchronous, bouncing
//           key_press   one-cycle pulse per confirmed press
//           key_release one-cycle pulse per confirmed release (0 unless the
//                       filter is built with KEY_RELEASE_PULSE_EN)
//           key_level   debounced key level, 1 = pressed
//           filt_state  current filter state, for debug
// Modports: master drives key_in and observes the filter outputs;
//           slave is the filter itself.
// ---------------------------------------------------------------------------
interface key_filter_if;
  logic       key_in;
  logic       key_press;
  logic       key_release;
  logic       key_level;
  logic [1:0] filt_state;

  modport master (
    output key_in,
    input  key_press,
    input  key_release,
    input  key_level,
    input  filt_state
  );

  modport slave (
    input  key_in,
    output key_press,
    output key_release,
    output key_level,
    output filt_state
  );
endinterface

// File: rtl/key_filter.sv
// ---------------------------------------------------------------------------
// key_filter
// Purpose : debounces a mechanical key. The raw level is synchronised, then a
//           four-state filter only accepts a new level after it has been seen
//           unchanged for a full CNT_MAX-cycle window. Confirmed presses (and
//           optionally releases) are reported as one-cycle pulses.
// Params  : CNT_MAX    debounce window in clk cycles (>= 2)
//           KEY_ACTIVE key_in level that means "pressed"
// Ports   : clk        system clock, rising edge
//           rst_n      asynchronous active-low reset
//           bus        key_filter_if.slave (key_in in; key_press, key_release,
//                      key_level, filt_state out)
// Build   : define KEY_RELEASE_PULSE_EN to build the release pulse register;
//           without it key_release is tied low.
// ---------------------------------------------------------------------------
module key_filter #(
  parameter int   CNT_MAX    = 1000000,
  parameter logic KEY_ACTIVE = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  key_filter_if.slave bus
);

  localparam int             CntWidth = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    PRESS_FILT = 2'b01,
    DOWN       = 2'b10,
    REL_FILT   = 2'b11
  } state_e;

  logic                syncA_q;
  logic                syncB_q;
  logic                keyActive;
  state_e              state_q;
  state_e              state_d;
  state_e              prevState_q;
  logic [CntWidth-1:0] count_q;
  logic [CntWidth-1:0] count_d;
  logic                keyPress_q;
  logic                keyPress_d;

  // Two-flop synchroniser; both stages come out of reset at the released
  // level so a reset never looks like a key edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncA_q <= ~KEY_ACTIVE;
      syncB_q <= ~KEY_ACTIVE;
    end else begin
      syncA_q <= bus.key_in;
      syncB_q <= syncA_q;
    end
  end

  assign keyActive = (syncB_q == KEY_ACTIVE);

  // State, window counter, previous state and the registered press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prevState_q <= IDLE;
      count_q     <= '0;
      keyPress_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prevState_q <= state_q;
      count_q     <= count_d;
      keyPress_q  <= keyPress_d;
    end
  end

  // Next-state logic. The counter defaults to zero, so it clears on every
  // transition and rests at zero in the stable states; it only advances
  // while a filter window is still open, so it can never wrap.
  // The press pulse is taken from the first DOWN cycle after PRESS_FILT and
  // registered, which places it one edge after the state change.
  always_comb begin
    state_d    = state_q;
    count_d    = '0;
    keyPress_d = (state_q == DOWN) && (prevState_q == PRESS_FILT);
    case (state_q)
      IDLE: begin
        if (keyActive) begin
          state_d = PRESS_FILT;
        end
      end
      PRESS_FILT: begin
        if (!keyActive) begin
          state_d = IDLE;
        end else if (count_q == CntLast) begin
          state_d = DOWN;
        end else begin
          count_d = count_q + CntWidth'(1);
        end
      end
      DOWN: begin
        if (!keyActive) begin
          state_d = REL_FILT;
        end
      end
      REL_FILT: begin
        if (keyActive) begin
          state_d = DOWN;
        end else if (count_q == CntLast) begin
          state_d = IDLE;
        end else begin
          count_d = count_q + CntWidth'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef KEY_RELEASE_PULSE_EN
  logic keyRelease_q;

  // Release pulse mirrors the press pulse: first IDLE cycle after REL_FILT,
  // registered one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keyRelease_q <= 1'b0;
    end else begin
      keyRelease_q <= (state_q == IDLE) && (prevState_q == REL_FILT);
    end
  end

  assign bus.key_release = keyRelease_q;
`else
  assign bus.key_release = 1'b0;
`endif

  assign bus.key_press  = keyPress_q;
  assign bus.key_level  = (state_q == DOWN) || (state_q == REL_FILT);
  assign bus.filt_state = state_q;

endmodule

// File: tb/tb_key_filter.sv
// ---------------------------------------------------------------------------
// tb_key_filter
// Directed and randomised key waveforms against a run-length model of the
// debouncer: the debounced level flips once the synchronised key has
// disagreed with it for CNT_MAX+1 consecutive samples; pulses follow one
// edge after the flip.
// ---------------------------------------------------------------------------
module tb_key_filter;

  localparam int   CNT_MAX    = 4;
  localparam logic KEY_ACTIVE = 1'b0;
  localparam int   LATENCY    = CNT_MAX + 3;
`ifdef KEY_RELEASE_PULSE_EN
  localparam int   RELEASE_EDGE = LATENCY;
`else
  localparam int   RELEASE_EDGE = -1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  key_filter_if kfIf ();

  key_filter #(
    .CNT_MAX    (CNT_MAX),
    .KEY_ACTIVE (KEY_ACTIVE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (kfIf)
  );

  always #5 clk = ~clk;

  int   nAsserts = 0;
  int   nFails   = 0;

  // Reference model state
  logic mSyncA;
  logic mSyncB;
  logic mLevel;
  int   mRun;
  logic mPendPress;
  logic mPendRelease;
  logic expPress;
  logic expRelease;
  int   expPressCount;
  int   obsPressCount;

  int   firstPress;
  int   firstRelease;

  // Reset both the DUT and the model, then check the reset values while
  // reset is still asserted.
  task automatic doReset(input string tag);
    rst_n         = 1'b0;
    mSyncA        = ~KEY_ACTIVE;
    mSyncB        = ~KEY_ACTIVE;
    mLevel        = 1'b0;
    mRun          = 0;
    mPendPress    = 1'b0;
    mPendRelease  = 1'b0;
    expPress      = 1'b0;
    expRelease    = 1'b0;
    expPressCount = 0;
    obsPressCount = 0;
    #1;
    checkOutput(tag);
    #1;
    rst_n = 1'b1;
  endtask

  // Model update for one rising edge.
  task automatic modelEdge();
    logic ks;
    logic pressed;
    ks           = mSyncB;
    mSyncB       = mSyncA;
    mSyncA       = kfIf.key_in;
    expPress     = mPendPress;
    expRelease   = mPendRelease;
    mPendPress   = 1'b0;
    mPendRelease = 1'b0;
    pressed      = (ks == KEY_ACTIVE);
    if (pressed != mLevel) begin
      mRun++;
      if (mRun == CNT_MAX + 1) begin
        mLevel = pressed;
        mRun   = 0;
        if (pressed) mPendPress = 1'b1;
        else         mPendRelease = 1'b1;
      end
    end else begin
      mRun = 0;
    end
    if (expPress) expPressCount++;
  endtask

  task automatic checkOutput(input string tag);
    logic [1:0] expState;
    logic       expRel;
    expState = {mLevel, (mRun != 0)};
`ifdef KEY_RELEASE_PULSE_EN
    expRel = expRelease;
`else
    expRel = 1'b0;
`endif
    nAsserts++;
    assert (kfIf.filt_state === expState) else begin
      nFails++;
      $error("[TB] FAIL %s filt_state: observed %b expected %b", tag, kfIf.filt_state, expState);
    end
    nAsserts++;
    assert (kfIf.key_level === mLevel) else begin
      nFails++;
      $error("[TB] FAIL %s key_level: observed %b expected %b", tag, kfIf.key_level, mLevel);
    end
    nAsserts++;
    assert (kfIf.key_press === expPress) else begin
      nFails++;
      $error("[TB] FAIL %s key_press: observed %b expected %b", tag, kfIf.key_press, expPress);
    end
    nAsserts++;
    assert (kfIf.key_release === expRel) else begin
      nFails++;
      $error("[TB] FAIL %s key_release: observed %b expected %b", tag, kfIf.key_release, expRel);
    end
    if (kfIf.key_press === 1'b1) obsPressCount++;
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold key_in at k for n edges, checking every cycle; report the edge
  // index (0 = first edge sampling k) of the first press/release pulse.
  task automatic applyStimulus(input logic k, input int n, input string tag,
                               output int pressAt, output int releaseAt);
    kfIf.key_in = k;
    pressAt     = -1;
    releaseAt   = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput(tag);
      if (kfIf.key_press === 1'b1 && pressAt < 0) pressAt = i;
      if (kfIf.key_release === 1'b1 && releaseAt < 0) releaseAt = i;
    end
  endtask

  initial begin
    kfIf.key_in = 1'b1;
    #1;
    doReset("reset");
    applyStimulus(1'b1, 5, "idle", firstPress, firstRelease);

    // Clean press: one pulse at the full latency, level high, DOWN.
    applyStimulus(1'b0, 20, "press", firstPress, firstRelease);
    checkInt("press_latency", firstPress, LATENCY);
    checkInt("press_level", int'(kfIf.key_level), 1);
    checkInt("press_state", int'(kfIf.filt_state), 2);

    // Short release bounce while pressed: back to DOWN, no pulses.
    applyStimulus(1'b1, 2, "rel_bounce", firstPress, firstRelease);
    applyStimulus(1'b0, 10, "rel_bounce_back", firstPress, firstRelease);
    checkInt("rel_bounce_no_press", firstPress, -1);
    checkInt("rel_bounce_no_release", firstRelease, -1);
    checkInt("rel_bounce_level", int'(kfIf.key_level), 1);

    // Clean release.
    applyStimulus(1'b1, 20, "release", firstPress, firstRelease);
    checkInt("release_latency", firstRelease, RELEASE_EDGE);
    checkInt("release_level", int'(kfIf.key_level), 0);

    // Press bounce shorter than the window.
    applyStimulus(1'b0, 3, "short_press", firstPress, firstRelease);
    applyStimulus(1'b1, 10, "short_press_end", firstPress, firstRelease);
    checkInt("short_press_no_pulse", firstPress, -1);
    checkInt("short_press_state", int'(kfIf.filt_state), 0);

    // Reset in the middle of a press window, then a full window again.
    applyStimulus(1'b0, 5, "pre_reset", firstPress, firstRelease);
    checkInt("pre_reset_state", int'(kfIf.filt_state), 1);
    doReset("mid_window_reset");
    applyStimulus(1'b0, 20, "post_reset", firstPress, firstRelease);
    checkInt("post_reset_latency", firstPress, LATENCY);

    // Two clean presses step the downstream stepper IDLE -> S1 -> S2.
    applyStimulus(1'b1, 12, "step_prep", firstPress, firstRelease);
    doReset("step_reset");
    applyStimulus(1'b0, 12, "step_press1", firstPress, firstRelease);
    applyStimulus(1'b1, 12, "step_release", firstPress, firstRelease);
    applyStimulus(1'b0, 12, "step_press2", firstPress, firstRelease);
    checkInt("stepper_state", obsPressCount, 2);

    // Random bouncing with occasional resets.
    for (int s = 0; s < 200; s++) begin
      if ($urandom_range(0, 39) == 0) doReset("rand_reset");
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)),
                    "random", firstPress, firstRelease);
    end
    checkInt("random_press_count", obsPressCount, expPressCount);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/key_filter.md
KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 Parameter CNT_MAX, default 1000000: debounce window in clk cycles (20 ms at 50 MHz); legal range >= 2.
REQ-002 Parameter KEY_ACTIVE, default 1'b0: key_in level that means "pressed" (active-low keys).
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 key_in  input  1  raw mechanical key, asynchronous to clk, bouncing.
REQ-006 key_press  output  1  one-cycle pulse per confirmed press; drives the enable input of the downstream state-stepping FSM.
REQ-007 key_release  output  1  one-cycle pulse per confirmed release; exists only under REQ-024.
REQ-008 key_level  output  1  debounced key level, 1 = pressed.
REQ-009 filt_state  output  2  current filter state, for debug.

Function
REQ-010 key_in SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the second flop output (key_s).
REQ-011 The FSM SHALL have four states: IDLE=2'b00 (released, stable), PRESS_FILT=2'b01, DOWN=2'b10 (pressed, stable), REL_FILT=2'b11.
REQ-012 IDLE: key_s==KEY_ACTIVE -> PRESS_FILT; else stay.
REQ-013 PRESS_FILT: key_s!=KEY_ACTIVE -> IDLE (bounce, no pulse); else count; count==CNT_MAX-1 -> DOWN.
REQ-014 DOWN: key_s!=KEY_ACTIVE -> REL_FILT; else stay.
REQ-015 REL_FILT: key_s==KEY_ACTIVE -> DOWN (bounce, no pulse); else count; count==CNT_MAX-1 -> IDLE.
REQ-016 Counter width SHALL be $clog2(CNT_MAX); counter SHALL clear to 0 on every state transition and hold 0 in IDLE and DOWN; it never wraps.
REQ-017 key_press SHALL be registered and high for exactly the first cycle the FSM is in DOWN after PRESS_FILT; a REL_FILT->DOWN return SHALL NOT pulse.
REQ-018 Press latency: key_press SHALL assert CNT_MAX+3 rising edges after the first edge that samples key_in at KEY_ACTIVE, provided key_in stays active.
REQ-019 key_level SHALL be 1 in DOWN and REL_FILT, 0 in IDLE and PRESS_FILT.
REQ-020 Any key_s change in a filter state SHALL abort that window in the same cycle; no partial count is kept.
REQ-021 Default case (unreachable) SHALL force IDLE.

Reset
REQ-022 On rst_n low: FSM=IDLE, counter=0, key_press=0, key_release=0, key_level=0, both synchronizer flops = ~KEY_ACTIVE.
REQ-023 Reset asserted mid-window SHALL discard the window; after release a full CNT_MAX window is needed before any pulse.

Configuration
REQ-024 Macro KEY_RELEASE_PULSE_EN: defined -> key_release is high for exactly the first cycle in IDLE after REL_FILT (latency mirrors REQ-018); undefined -> key_release is tied to 0 and its register is not built.

Verification (CNT_MAX=4, KEY_ACTIVE=0)
REQ-025 key_in 1->0 held 20 cycles -> single key_press pulse 7 edges after first low sample; key_level=1; filt_state=2'b10.
REQ-026 key_in low 3 cycles then high -> no key_press; filt_state returns to 2'b00; key_level stays 0.
REQ-027 In DOWN, key_in high 2 cycles then low -> filt_state 10->11->10; no key_press, no key_release; key_level stays 1.
REQ-028 With KEY_RELEASE_PULSE_EN, pressed key released and held high -> one key_release pulse 7 edges later, key_level=0; without macro key_release stays 0.
REQ-029 rst_n pulsed low while in PRESS_FILT at count 2 -> all outputs 0 and filt_state=00 immediately; key_in held low afterward -> key_press only after a full 7-edge latency.
REQ-030 Two clean presses separated by a clean release -> exactly two key_press pulses; downstream FSM steps IDLE->S1->S2.
